// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 5;
    localparam int unsigned NUM_READ_DEF   = 2;
    localparam int unsigned NUM_READ_MAX   = 4;

    // LSB position of a port's field inside a packed multi-port vector.
    function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write tracking: issue reserves, writeback releases, flush clears all.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en_i,
    input  logic [ADDR_WIDTH-1:0]        wr_addr_i,
    input  logic                         iss_en_i,
    input  logic [ADDR_WIDTH-1:0]        iss_addr_i,
    input  logic                         flush_i,
    output logic [(1<<ADDR_WIDTH)-1:0]   busy_o,
    output logic                         err_o
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

    logic [DEPTH-1:0] busy_q, busy_d;
    logic             err_q, err_d;
    logic             iss_zero;
    logic             iss_legal;

    assign iss_zero  = (ZERO_REG != 0) && (iss_addr_i == '0);
    // A same-cycle writeback to the reserved register frees it for the new producer.
    assign iss_legal = iss_zero || !busy_q[iss_addr_i] || (wr_en_i && (wr_addr_i == iss_addr_i));

    always_comb begin
        busy_d = busy_q;
        err_d  = err_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            if (wr_en_i) begin
                busy_d[wr_addr_i] = 1'b0;
            end
            if (iss_en_i) begin
                if (!iss_legal) begin
                    err_d = 1'b1;
                end else if (!iss_zero) begin
                    busy_d[iss_addr_i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign busy_o = busy_q;
    assign err_o  = err_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with combinational read ports, write-first bypass and hazard scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned NUM_READ   = NUM_READ_DEF,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
    input  logic [NUM_READ-1:0]            rd_use,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_READ-1:0]            rd_busy,
    output logic                           stall,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           iss_en,
    input  logic [ADDR_WIDTH-1:0]          iss_addr,
    output logic                           iss_ready,
    input  logic                           flush,
    output logic                           err
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

    if ((NUM_READ < 1) || (NUM_READ > NUM_READ_MAX)) begin : g_bad_num_read
        $error("regfile_sb: NUM_READ out of range");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic                  wr_ok;
    logic                  iss_zero;
    logic                  iss_hit;

    assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .iss_en_i   (iss_en),
        .iss_addr_i (iss_addr),
        .flush_i    (flush),
        .busy_o     (busy),
        .err_o      (err)
    );

    // Each read port: zero register, then same-cycle writeback bypass, then array.
    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        localparam int unsigned AL = port_lsb(i, ADDR_WIDTH);
        localparam int unsigned DL = port_lsb(i, DATA_WIDTH);

        logic [ADDR_WIDTH-1:0] addr;
        logic                  zero;
        logic                  hit;

        assign addr = rd_addr[AL +: ADDR_WIDTH];
        assign zero = (ZERO_REG != 0) && (addr == '0);
        assign hit  = wr_en && (wr_addr == addr);

        assign rd_data[DL +: DATA_WIDTH] = zero ? '0 : (hit ? wr_data : mem_q[addr]);
        assign rd_busy[i]                = busy[addr] && !hit && !zero;
    end

    assign stall = |(rd_use & rd_busy);

    assign iss_zero  = (ZERO_REG != 0) && (iss_addr == '0);
    assign iss_hit   = wr_en && (wr_addr == iss_addr);
    assign iss_ready = iss_zero || !busy[iss_addr] || iss_hit;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the pipeline's integer register file.
- Provides NUM_READ combinational read ports, one synchronous write port with write-first bypass, an optional hardwired-zero register, asynchronous reset of all contents, and a per-register pending-write scoreboard.
- Sits between decode (reads, issue reservations) and writeback (commits); drives the decode stall.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH.
- NUM_READ, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rd_addr  input  NUM_READ*ADDR_WIDTH  read addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rd_use  input  NUM_READ  port i operand is consumed this cycle.
- rd_data  output  NUM_READ*DATA_WIDTH  read data, packed as rd_addr.
- rd_busy  output  NUM_READ  addressed register has a pending write.
- stall  output  1  OR over i of (rd_use[i] & rd_busy[i]).
- wr_en  input  1  writeback commit.
- wr_addr  input  ADDR_WIDTH  writeback destination.
- wr_data  input  DATA_WIDTH  writeback value.
- iss_en  input  1  reserve a destination (instruction leaves decode).
- iss_addr  input  ADDR_WIDTH  destination to reserve.
- iss_ready  output  1  iss_addr is not busy (or is reg 0 with ZERO_REG=1).
- flush  input  1  clear every busy bit (pipeline flush).
- err  output  1  sticky error flag.

Behaviour:
- Interface (decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: all registers 0, all busy bits 0, err 0. With no read addresses driven, rd_data = 0, rd_busy = 0, stall = 0, iss_ready = 1. Reset asserted mid-operation discards pending reservations immediately, without waiting for a clock edge.
- Storage: array of 2**ADDR_WIDTH x DATA_WIDTH.
- Write: a rising edge with wr_en=1 writes wr_data to wr_addr, except address 0 when ZERO_REG=1.
- Read: combinational, zero latency.
  - If wr_en and wr_addr == rd_addr[i] (and not a ZERO_REG reg-0 case), rd_data[i] = wr_data (write-first bypass).
  - Otherwise rd_data[i] = array content.
  - ZERO_REG=1 and rd_addr[i] == 0: rd_data[i] = 0.
- Scoreboard (one busy bit per register), next-state priority on a rising edge:
  - flush=1: all bits clear. Same-cycle iss_en and wr_en are ignored for the scoreboard; the data write still happens.
  - Otherwise, wr_en clears busy[wr_addr], then a legal iss_en sets busy[iss_addr]. When both target the same address the bit ends set, because the new producer wins.
  - An issue is legal when busy[iss_addr]==0, or when iss_addr equals wr_addr with wr_en=1 in the same cycle.
  - An illegal issue (WAW on a pending register) is dropped and sets err.
  - wr_en to a non-busy register is allowed: data is written, the bit stays 0, err is unaffected.
- rd_busy[i] (combinational) = busy[rd_addr[i]] & ~(wr_en & wr_addr == rd_addr[i]). A same-cycle writeback resolves the hazard through the bypass. It is forced to 0 for reg 0 when ZERO_REG=1.
- iss_ready uses the same bypass rule as rd_busy, applied to iss_addr.
- ZERO_REG=1: iss_en to reg 0 is legal and leaves busy[0]=0.
- err: sticky; cleared only by rst_n.
- No internal pipeline. The only sequential latency is 1 cycle from an iss_en or wr_en edge to the busy bit updating.

Decomposition:
- Shared package regfile_pkg holds the default widths and a function for packed read-port slicing.
- One natural sub-module, regfile_scoreboard: busy vector, issue/clear/flush priority, err.
- The data array and bypass stay in the top.

Test Plan:
- Reset: drive rst_n=0 mid-cycle after writing x5=0x1234 -> x5 reads 0 and all busy bits read 0 immediately, without a clock edge; err=0.
- Bypass: wr_en=1, wr_addr=3, wr_data=0xDEADBEEF, rd_addr[0]=3 in the same cycle -> rd_data[0]=0xDEADBEEF before the edge, and the same value after it.
- Zero register: write 0xFFFFFFFF to x0 -> rd_data=0. iss_en to x0 -> iss_ready=1, rd_busy=0, err=0.
- Hazard: iss_en x7, next cycle rd_addr[1]=7 with rd_use[1]=1 -> rd_busy[1]=1, stall=1. Writeback x7=0x42 that cycle -> stall=0, rd_data[1]=0x42. Next cycle busy[7]=0.
- WAW and flush: iss x9 twice in consecutive cycles -> second issue dropped, err=1 (sticky). Then flush=1 -> all busy=0; err stays 1.
- Simultaneous issue and writeback: iss_en x4 and wr_en x4 in the same cycle while x4 is busy -> data written, busy[4] remains 1, err=0.
